// File: rtl/i2c_master_frame_ctrl.sv
// i2c_master_frame_ctrl: turns one 16-bit-address / 32-bit-data register access
// into START / WRITE / RSTART / READ / STOP commands for an I2C master byte engine.
module i2c_master_frame_ctrl #(
   parameter logic [6:0] DEV_ADDR = 7'h50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [1:0]  rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        busy,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd_op,
   output logic [7:0]  cmd_byte,
   input  logic        cmd_done,
   input  logic        cmd_ack,
   input  logic [7:0]  cmd_rxbyte,
   input  logic        bus_lost
);
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_DEV_W, S_ADDR_HI, S_ADDR_LO, S_WDATA,
      S_RSTART, S_DEV_R, S_RDATA, S_STOP, S_RESP
   } state_t;

   state_t      r_state;
   logic        r_wait;
   logic        r_write;
   logic [15:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [1:0]  r_cnt;
   logic [1:0]  r_err;
   logic        r_cmd_valid;
   logic [2:0]  r_cmd_op;
   logic [7:0]  r_cmd_byte;
   logic        r_rsp_valid;
   logic [1:0]  r_rsp_err;
   logic [31:0] r_rsp_rdata;

   state_t      w_nxt;
   logic [1:0]  w_nxt_cnt;
   logic        w_nack;

   function automatic logic [2:0] f_op(input state_t s, input logic [1:0] c);
      return s == S_START  ? 3'd0 :
             s == S_RSTART ? 3'd1 :
             s == S_STOP   ? 3'd5 :
             s == S_RDATA  ? (c == 2'd3 ? 3'd4 : 3'd3) : 3'd2;
   endfunction

   function automatic logic [7:0] f_byte(input state_t s, input logic [1:0] c,
                                         input logic [15:0] a, input logic [31:0] d);
      logic [7:0] b;
      b = c == 2'd0 ? d[31:24] : c == 2'd1 ? d[23:16] : c == 2'd2 ? d[15:8] : d[7:0];
      return s == S_DEV_W   ? {DEV_ADDR, 1'b0} :
             s == S_DEV_R   ? {DEV_ADDR, 1'b1} :
             s == S_ADDR_HI ? a[15:8] :
             s == S_ADDR_LO ? a[7:0] :
             s == S_WDATA   ? b : 8'h00;
   endfunction

   // A NACK on any byte write abandons the rest of the frame but still closes with STOP.
   always_comb begin
      w_nack    = r_cmd_op == 3'd2 && !cmd_ack;
      w_nxt_cnt = (r_state == S_WDATA || r_state == S_RDATA) ? r_cnt + 2'd1 : r_cnt;
      w_nxt     = S_STOP;
      if (!w_nack)
         case (r_state)
            S_START:   w_nxt = S_DEV_W;
            S_DEV_W:   w_nxt = S_ADDR_HI;
            S_ADDR_HI: w_nxt = S_ADDR_LO;
            S_ADDR_LO: w_nxt = r_write ? S_WDATA : S_RSTART;
            S_WDATA:   w_nxt = r_cnt == 2'd3 ? S_STOP : S_WDATA;
            S_RSTART:  w_nxt = S_DEV_R;
            S_DEV_R:   w_nxt = S_RDATA;
            S_RDATA:   w_nxt = r_cnt == 2'd3 ? S_STOP : S_RDATA;
            S_STOP:    w_nxt = S_RESP;
            default:   w_nxt = S_IDLE;
         endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wait      <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_cnt       <= '0;
         r_err       <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_op    <= '0;
         r_cmd_byte  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (r_state == S_IDLE) begin
            if (req_valid) begin
               r_state     <= S_START;
               r_wait      <= 1'b0;
               r_write     <= req_write;
               r_addr      <= req_addr;
               r_wdata     <= req_wdata;
               r_rdata     <= '0;
               r_cnt       <= '0;
               r_err       <= '0;
               r_cmd_valid <= 1'b1;
               r_cmd_op    <= 3'd0;
               r_cmd_byte  <= 8'h00;
            end
         end else if (r_state == S_RESP) begin
            r_state <= S_IDLE;
         end else if (bus_lost) begin
            r_state     <= S_RESP;
            r_err       <= 2'b10;
            r_cmd_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 2'b10;
            r_rsp_rdata <= '0;
         end else if (!r_wait) begin
            if (cmd_ready) begin
               r_cmd_valid <= 1'b0;
               r_wait      <= 1'b1;
            end
         end else if (cmd_done) begin
            r_wait <= 1'b0;
            r_cnt  <= w_nxt_cnt;
            if (r_state == S_RDATA)
               r_rdata <= {r_rdata[23:0], cmd_rxbyte};
            if (w_nack)
               r_err <= 2'b01;
            r_state <= w_nxt;
            if (w_nxt == S_RESP) begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= r_err;
               r_rsp_rdata <= (r_err == 2'b00 && !r_write) ? r_rdata : '0;
            end else begin
               r_cmd_valid <= 1'b1;
               r_cmd_op    <= f_op(w_nxt, w_nxt_cnt);
               r_cmd_byte  <= f_byte(w_nxt, w_nxt_cnt, r_addr, r_wdata);
            end
         end
      end
   end

   assign req_ready = r_state == S_IDLE;
   assign busy      = r_state != S_IDLE;
   assign cmd_valid = r_cmd_valid;
   assign cmd_op    = r_cmd_op;
   assign cmd_byte  = r_cmd_byte;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_i2c_master_frame_ctrl.sv
// tb_i2c_master_frame_ctrl: byte-engine model with a command scoreboard; each
// scenario task drives a request and checks the response inline.
module tb_i2c_master_frame_ctrl;
   localparam logic [6:0] DEV = 7'h50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready, rsp_valid, busy, cmd_valid;
   logic [1:0]  rsp_err;
   logic [31:0] rsp_rdata;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_byte;
   logic        cmd_ready = 1'b1, cmd_done = 1'b0, cmd_ack = 1'b0, bus_lost = 1'b0;
   logic [7:0]  cmd_rxbyte = '0;

   always #5 clk = ~clk;

   i2c_master_frame_ctrl #(.DEV_ADDR(DEV)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_byte(cmd_byte),
      .cmd_done(cmd_done), .cmd_ack(cmd_ack), .cmd_rxbyte(cmd_rxbyte), .bus_lost(bus_lost)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0, n_total = 0;
   logic [10:0] q_exp[$];
   logic [7:0]  rx_q[$];
   int acc = 0, nack_at = -1, lost_at = -1, stall_at = -1, stall_left = 0;
   bit pend = 0;
   int pend_idx = 0;
   logic [2:0]  pend_op = '0;
   logic [10:0] e_exp;

   // Byte engine: done one cycle after accept; ACK, rx bytes, bus loss and stalls are scripted.
   always @(negedge clk) begin
      cmd_done = 1'b0; bus_lost = 1'b0; cmd_ack = 1'b0; cmd_rxbyte = 8'h00;
      if (pend) begin
         cmd_done = 1'b1;
         cmd_ack  = pend_idx != nack_at;
         bus_lost = pend_idx == lost_at;
         if ((pend_op == 3'd3 || pend_op == 3'd4) && rx_q.size() > 0) cmd_rxbyte = rx_q.pop_front();
         pend = 0;
      end
      cmd_ready = 1'b1;
      if (cmd_valid === 1'b1 && acc == stall_at && stall_left > 0) begin
         cmd_ready = 1'b0;
         stall_left--;
         n_total++;
         if (q_exp.size() > 0 && {cmd_op, cmd_byte} === q_exp[0]) n_pass++;
         else $display("FAIL stall_hold op/byte=%h required %h", {cmd_op, cmd_byte}, q_exp.size() > 0 ? q_exp[0] : 11'h0);
      end else if (cmd_valid === 1'b1) begin
         n_total++;
         if (q_exp.size() == 0) $display("FAIL cmd_extra idx=%0d op/byte=%h required none", acc, {cmd_op, cmd_byte});
         else begin
            e_exp = q_exp.pop_front();
            if ({cmd_op, cmd_byte} === e_exp) n_pass++;
            else $display("FAIL cmd_seq idx=%0d op/byte=%h required %h", acc, {cmd_op, cmd_byte}, e_exp);
         end
         pend = 1; pend_idx = acc; pend_op = cmd_op; acc++;
      end
   end

   task automatic build_frame(input bit wr, input logic [15:0] a, input logic [31:0] d,
                              input int nk, input int lk);
      logic [10:0] f[$];
      f.push_back({3'd0, 8'h00});
      f.push_back({3'd2, DEV, 1'b0});
      f.push_back({3'd2, a[15:8]});
      f.push_back({3'd2, a[7:0]});
      if (wr) for (int i = 0; i < 4; i++) f.push_back({3'd2, d[31-8*i -: 8]});
      else begin
         f.push_back({3'd1, 8'h00});
         f.push_back({3'd2, DEV, 1'b1});
         for (int i = 0; i < 4; i++) f.push_back({(i == 3) ? 3'd4 : 3'd3, 8'h00});
      end
      f.push_back({3'd5, 8'h00});
      if (lk >= 0) f = f[0:lk];
      else if (nk >= 0) begin f = f[0:nk]; f.push_back({3'd5, 8'h00}); end
      foreach (f[i]) q_exp.push_back(f[i]);
   endtask

   task automatic do_txn(input bit wr, input logic [15:0] a, input logic [31:0] d,
                         input int nk, input int lk, input int sk, input int sn,
                         output int lat, output logic [1:0] err, output logic [31:0] rd,
                         output bit ok);
      int base, t0;
      base = acc;
      nack_at = nk < 0 ? -1 : base + nk;
      lost_at = lk < 0 ? -1 : base + lk;
      stall_at = sk < 0 ? -1 : base + sk;
      stall_left = sn;
      build_frame(wr, a, d, nk, lk);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; t0 = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      ok = 0; lat = -1; err = 'x; rd = 'x;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (rsp_valid === 1'b1) begin ok = 1; lat = cyc - t0; err = rsp_err; rd = rsp_rdata; end
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata, busy, cmd_valid, cmd_op, cmd_byte} === {1'b1, 48'b0}) n_pass++;
      else $display("FAIL reset_vals got rdy=%b rv=%b err=%b rd=%h busy=%b cv=%b op=%0d byte=%h required rdy=1 rest 0",
                    req_ready, rsp_valid, rsp_err, rsp_rdata, busy, cmd_valid, cmd_op, cmd_byte);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      int lat; logic [1:0] err; logic [31:0] rd; bit ok;
      do_txn(1, 16'h1234, 32'hDEADBEEF, -1, -1, -1, 0, lat, err, rd, ok);
      n_total++; if (ok && lat == 19) n_pass++; else $display("FAIL wr_latency got %0d required 19", lat);
      n_total++; if (err === 2'b00) n_pass++; else $display("FAIL wr_err got %b required 00", err);
      n_total++; if (rd === 32'h0) n_pass++; else $display("FAIL wr_rdata got %h required 0", rd);
      n_total++; if (busy === 1'b1 && req_ready === 1'b0) n_pass++;
      else $display("FAIL wr_resp_flags got busy=%b rdy=%b required busy=1 rdy=0", busy, req_ready);
      @(negedge clk);
      n_total++; if (busy === 1'b0 && req_ready === 1'b1 && rsp_valid === 1'b0) n_pass++;
      else $display("FAIL wr_idle_flags got busy=%b rdy=%b rv=%b required 0 1 0", busy, req_ready, rsp_valid);
      n_total++; if (q_exp.size() == 0) n_pass++; else $display("FAIL wr_cmds_left got %0d required 0", q_exp.size());
      n_total++; if (rsp_err === 2'b00 && rsp_rdata === 32'h0) n_pass++;
      else $display("FAIL wr_rsp_hold got err=%b rd=%h required 00 0", rsp_err, rsp_rdata);
   endtask

   task automatic test_read();
      int lat; logic [1:0] err; logic [31:0] rd; bit ok;
      rx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_txn(0, 16'h0010, 32'h0, -1, -1, -1, 0, lat, err, rd, ok);
      n_total++; if (ok && lat == 23) n_pass++; else $display("FAIL rd_latency got %0d required 23", lat);
      n_total++; if (err === 2'b00) n_pass++; else $display("FAIL rd_err got %b required 00", err);
      n_total++; if (rd === 32'h11223344) n_pass++; else $display("FAIL rd_rdata got %h required 11223344", rd);
      repeat (3) @(negedge clk);
      n_total++; if (rsp_rdata === 32'h11223344) n_pass++; else $display("FAIL rd_hold got %h required 11223344", rsp_rdata);
      n_total++; if (q_exp.size() == 0) n_pass++; else $display("FAIL rd_cmds_left got %0d required 0", q_exp.size());
   endtask

   task automatic test_nack();
      int lat; logic [1:0] err; logic [31:0] rd; bit ok;
      do_txn(1, 16'h1234, 32'hDEADBEEF, 3, -1, -1, 0, lat, err, rd, ok);
      n_total++; if (ok && lat == 11) n_pass++; else $display("FAIL nack_latency got %0d required 11", lat);
      n_total++; if (err === 2'b01) n_pass++; else $display("FAIL nack_err got %b required 01", err);
      n_total++; if (rd === 32'h0) n_pass++; else $display("FAIL nack_rdata got %h required 0", rd);
      @(negedge clk);
      n_total++; if (busy === 1'b0) n_pass++; else $display("FAIL nack_busy got %b required 0", busy);
      repeat (2) @(negedge clk);
      n_total++; if (q_exp.size() == 0) n_pass++; else $display("FAIL nack_cmds_left got %0d required 0", q_exp.size());
   endtask

   task automatic test_bus_lost();
      int lat; logic [1:0] err; logic [31:0] rd; bit ok;
      rx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      do_txn(0, 16'h0010, 32'h0, -1, 7, -1, 0, lat, err, rd, ok);
      n_total++; if (ok && lat == 17) n_pass++; else $display("FAIL lost_latency got %0d required 17", lat);
      n_total++; if (err === 2'b10) n_pass++; else $display("FAIL lost_err got %b required 10", err);
      n_total++; if (rd === 32'h0) n_pass++; else $display("FAIL lost_rdata got %h required 0", rd);
      n_total++; if (cmd_valid === 1'b0) n_pass++; else $display("FAIL lost_cmd_valid got %b required 0", cmd_valid);
      repeat (4) @(negedge clk);
      n_total++; if (q_exp.size() == 0 && acc - pend_idx == 1) n_pass++;
      else $display("FAIL lost_cmds_left got %0d required 0", q_exp.size());
      lost_at = -1;
      rx_q.delete();
   endtask

   task automatic test_stall();
      int lat; logic [1:0] err; logic [31:0] rd; bit ok;
      do_txn(1, 16'hBEEF, 32'h01020304, -1, -1, 1, 5, lat, err, rd, ok);
      n_total++; if (ok && lat == 24) n_pass++; else $display("FAIL stall_latency got %0d required 24", lat);
      n_total++; if (err === 2'b00) n_pass++; else $display("FAIL stall_err got %b required 00", err);
      n_total++; if (stall_left == 0) n_pass++; else $display("FAIL stall_cycles got %0d left required 0", stall_left);
      repeat (2) @(negedge clk);
      n_total++; if (q_exp.size() == 0) n_pass++; else $display("FAIL stall_cmds_left got %0d required 0", q_exp.size());
      stall_at = -1;
   endtask

   task automatic test_reset_mid();
      int lat, base; logic [1:0] err; logic [31:0] rd; bit ok, seen;
      base = acc; nack_at = -1; lost_at = -1; stall_at = -1;
      build_frame(1, 16'h1234, 32'hDEADBEEF, -1, -1);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 100 && acc - base < 7; i++) @(posedge clk);
      n_total++; if (acc - base == 7) n_pass++; else $display("FAIL rstmid_reach got %0d cmds required 7", acc - base);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++; if (cmd_valid === 1'b0 && req_ready === 1'b1 && busy === 1'b0) n_pass++;
      else $display("FAIL rstmid_idle got cv=%b rdy=%b busy=%b required 0 1 0", cmd_valid, req_ready, busy);
      rst = 1'b0;
      q_exp.delete();
      seen = 0;
      repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1; end
      n_total++; if (!seen) n_pass++; else $display("FAIL rstmid_no_rsp got rsp_valid=1 required 0");
      n_total++; if (acc - base == 7) n_pass++; else $display("FAIL rstmid_no_stop got %0d cmds required 7", acc - base);
      do_txn(1, 16'h5678, 32'hCAFEF00D, -1, -1, -1, 0, lat, err, rd, ok);
      n_total++; if (ok && lat == 19 && err === 2'b00) n_pass++;
      else $display("FAIL rstmid_fresh got lat=%0d err=%b required 19 00", lat, err);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int t0, lat; bit ok;
      nack_at = -1; lost_at = -1; stall_at = -1;
      build_frame(1, 16'h0A0B, 32'h11111111, -1, -1);
      build_frame(0, 16'h0C0D, 32'h0, -1, -1);
      rx_q = '{8'h55, 8'h66, 8'h77, 8'h88};
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0A0B; req_wdata = 32'h11111111; t0 = cyc;
      ok = 0; lat = -1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin ok = 1; lat = cyc - t0; end
      end
      n_total++; if (ok && lat == 19) n_pass++; else $display("FAIL b2b_first_lat got %0d required 19", lat);
      n_total++; if (req_ready === 1'b0) n_pass++; else $display("FAIL b2b_resp_ready got %b required 0", req_ready);
      req_write = 1'b0; req_addr = 16'h0C0D; req_wdata = 32'h0; t0 = cyc;
      @(negedge clk);
      n_total++; if (req_ready === 1'b1) n_pass++; else $display("FAIL b2b_idle_ready got %b required 1", req_ready);
      @(negedge clk);
      req_valid = 1'b0;
      ok = 0; lat = -1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (rsp_valid === 1'b1) begin ok = 1; lat = cyc - t0; end
         else @(negedge clk);
      end
      n_total++; if (ok && lat == 24) n_pass++; else $display("FAIL b2b_second_lat got %0d required 24", lat);
      n_total++; if (rsp_rdata === 32'h55667788 && rsp_err === 2'b00) n_pass++;
      else $display("FAIL b2b_rdata got %h err=%b required 55667788 00", rsp_rdata, rsp_err);
      repeat (2) @(negedge clk);
      n_total++; if (q_exp.size() == 0) n_pass++; else $display("FAIL b2b_cmds_left got %0d required 0", q_exp.size());
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_bus_lost();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/i2c_master_frame_ctrl.md
Name: i2c_master_frame_ctrl

Overview:
Register-access initiator for the I2C slave register bridge.
- Accepts one 16-bit-address / 32-bit-data read or write request.
- Sequences it as byte-level commands to an I2C master byte engine.
- Returns read data and completion status.
- Frame format: START, dev|W, addr_hi, addr_lo, then either 4 write bytes, or RSTART, dev|R, 4 read bytes. Ends with STOP. All fields MSB-first.

Parameters:
DEV_ADDR, 7'h50, 7-bit target slave address placed in bits [7:1] of the device byte.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_write  in  1  1=write, 0=read
req_addr  in  16  register address
req_wdata  in  32  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost
rsp_rdata  out  32  read data, 0 for writes
busy  out  1  high from request accept until rsp_valid inclusive
cmd_valid  out  1  command to byte engine
cmd_ready  in  1  engine accepts command
cmd_op  out  3  0 START, 1 RSTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
cmd_byte  out  8  byte for WRITE, 0 otherwise
cmd_done  in  1  engine completion pulse for accepted command
cmd_ack  in  1  with cmd_done on WRITE: 1=slave ACKed
cmd_rxbyte  in  8  with cmd_done on READ_*: received byte
bus_lost  in  1  arbitration-lost pulse from engine

Behaviour:
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, cmd_valid=0, cmd_op=0, cmd_byte=0. Latched addr/wdata/rdata and byte counter are cleared.
- Reset mid-transaction: return to IDLE next cycle. No STOP is issued, and no rsp_valid is produced.
- Request accept: on req_valid && req_ready, latch write, addr, wdata and clear the rdata shift register. cmd_valid rises the next cycle.
- States: IDLE, START, DEV_W, ADDR_HI, ADDR_LO, WDATA, RSTART, DEV_R, RDATA, STOP, RESP. Each command state has an ISSUE phase and a WAIT phase.
- ISSUE phase: cmd_valid=1, with cmd_op and cmd_byte held stable until cmd_ready. On acceptance, cmd_valid drops the next cycle and the state enters WAIT.
- WAIT phase: waits for cmd_done. cmd_done outside WAIT is ignored.
- Write path: START -> DEV_W (byte {DEV_ADDR,0}) -> ADDR_HI (addr[15:8]) -> ADDR_LO (addr[7:0]) -> WDATA. WDATA sends 4 bytes using a 2-bit counter 0..3: wdata[31:24] first, wdata[7:0] last. Then STOP -> RESP.
- Read path: after ADDR_LO -> RSTART -> DEV_R (byte {DEV_ADDR,1}) -> RDATA. RDATA issues READ_ACK for counter 0..2 and READ_NACK for counter 3. Each done shifts rdata <= {rdata[23:0], cmd_rxbyte}. Then STOP -> RESP.
- NACK: cmd_done with cmd_ack=0 on any WRITE command sets err=01. Remaining bytes are skipped and the block goes to STOP, then RESP. rsp_rdata=0.
- bus_lost: in any non-IDLE/non-RESP state, takes priority over cmd_done in the same cycle. err=10, go directly to RESP with no STOP. cmd_valid is deasserted the next cycle.
- RESP: single cycle. rsp_valid=1; rsp_rdata=shift register for successful reads, else 0; rsp_err set. Next cycle returns to IDLE, req_ready=1.
- rsp_rdata and rsp_err hold their values until the next RESP.
- Commands per transaction: write = 9 (START, 7 WRITE, STOP). Read = 11 (START, 3 WRITE, RSTART, WRITE, 3 READ_ACK, READ_NACK, STOP).
- Latency with zero-wait engine (cmd_ready=1, cmd_done one cycle after accept): 2 cycles per command. Request accepted at cycle 0, first cmd_valid at cycle 1.
  - Write: rsp_valid at cycle 19.
  - Read: rsp_valid at cycle 23.
- Back-to-back: req_valid held high during RESP is not accepted until the IDLE cycle after RESP.
- cmd_ready low: the block stalls indefinitely in ISSUE. There is no timeout.

Test Plan:
- Write addr=16'h1234, wdata=32'hDEADBEEF, zero-wait engine, all ACK -> cmd_byte sequence A0,12,34,DE,AD,BE,EF, then STOP; rsp_valid at cycle 19, rsp_err=00, rsp_rdata=0.
- Read addr=16'h0010, engine returns 11,22,33,44 -> ops START,WRITE(A0,00,10),RSTART,WRITE(A1),RACK×3,RNACK,STOP; rsp_rdata=32'h11223344 at cycle 23, err=00.
- Write with cmd_ack=0 on addr_lo byte -> no WDATA bytes sent, STOP issued, rsp_err=01, busy low the cycle after rsp_valid.
- bus_lost pulsed during the second READ_ACK wait, coincident with cmd_done -> no STOP command, rsp_err=10, rsp_rdata=0.
- cmd_ready held low 5 cycles on DEV_W -> cmd_valid, cmd_op=2, cmd_byte=A0 stable all 5 cycles, accepted exactly once; total latency +5.
- rst asserted mid-WDATA (after byte BE) -> next cycle cmd_valid=0, req_ready=1, no rsp_valid; a fresh write then completes normally.
